rx_symbol_slicer: RTL and testbench

Receive-chain stage directly downstream of the 21-tap RX matched filter. Takes the filter's 1s17 output at 4 samples per symbol, down-samples at a selectable phase, and slices each symbol to one of four 4-ASK levels. Decision thresholds adapt from a block average of |x|. Also produces the signed decision error and a block mean-squared error for MER measurement.

---
 rtl/rx_symbol_slicer.sv | 211 +++++++++++++++++++++
 tb/tb_rx_symbol_slicer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_slicer.sv
// rx_symbol_slicer: 4-ASK decimating slicer with block-adaptive threshold and MER statistics.
// Build macro RX_SLICER_ERR_POW_EN adds the squared-error accumulator; otherwise err_pow stays 0.
module rx_symbol_slicer_chk (
    input logic               clk,
    input logic               reset,
    input logic               sym_valid,
    input logic               stat_valid,
    input logic signed [17:0] ref_level
);
    // A statistics update always coincides with the decision of the block's last symbol.
    a_stat_with_sym: assert property (@(posedge clk) disable iff (reset)
        stat_valid |-> sym_valid);

    // The threshold only moves on a statistics pulse or out of reset.
    a_ref_hold: assert property (@(posedge clk) disable iff (reset)
        (!stat_valid && !$past(reset)) |-> $stable(ref_level));
endmodule

module rx_symbol_slicer #(
    parameter int                OSR      = 4,
    parameter int                ACC_LOG2 = 10,
    parameter logic signed [17:0] REF_INIT = 18'sd65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         phase,
    input  logic signed [17:0] x_in,
    output logic               sym_valid,
    output logic [1:0]         sym_out,
    output logic signed [17:0] sym_err,
    output logic signed [17:0] ref_level,
    output logic [17:0]        err_pow,
    output logic               stat_valid
);
    localparam int         ACC_W    = 18 + ACC_LOG2;
    localparam logic [1:0] CNT_LAST = 2'(OSR - 1);

    function automatic logic [17:0] abs_sat(input logic signed [17:0] v);
        logic [17:0] r;
        if (v == 18'sh20000) begin
            r = 18'h1FFFF;
        end else if (v < 18'sd0) begin
            r = 18'(-v);
        end else begin
            r = 18'(v);
        end
        return r;
    endfunction

    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        logic signed [17:0] r;
        if (v > 19'sd131071) begin
            r = 18'sd131071;
        end else if (v < -19'sd131072) begin
            r = 18'sh20000;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    logic [1:0]          cnt_r;
    logic                strobe_s;
    logic                v1_r;
    logic signed [17:0]  s1_r;
    logic [17:0]         abs1_r;
    logic signed [18:0]  s_ext_s;
    logic signed [18:0]  ref_ext_s;
    logic signed [18:0]  half_s;
    logic signed [18:0]  three_half_s;
    logic signed [18:0]  level_s;
    logic signed [18:0]  err_wide_s;
    logic signed [17:0]  err_s;
    logic [1:0]          dec_s;
    logic [ACC_LOG2-1:0] sym_cnt_r;
    logic                first_s;
    logic                last_s;
    logic [ACC_W-1:0]    abs_acc_r;
    logic [ACC_W-1:0]    abs_acc_next_s;

    assign strobe_s     = (cnt_r == phase);
    assign s_ext_s      = {s1_r[17], s1_r};
    assign ref_ext_s    = {ref_level[17], ref_level};
    assign half_s       = ref_ext_s >>> 1;
    assign three_half_s = ref_ext_s + half_s;

    // Decide the stage-1 sample against the current threshold and form the saturated error.
    always_comb begin
        dec_s   = 2'b00;
        level_s = 19'sd0;
        if (s_ext_s >= ref_ext_s) begin
            dec_s   = 2'b11;
            level_s = three_half_s;
        end else if (s_ext_s >= 19'sd0) begin
            dec_s   = 2'b10;
            level_s = half_s;
        end else if (s_ext_s >= -ref_ext_s) begin
            dec_s   = 2'b01;
            level_s = -half_s;
        end else begin
            dec_s   = 2'b00;
            level_s = -three_half_s;
        end
        err_wide_s = s_ext_s - level_s;
        err_s      = sat18(err_wide_s);
    end

    // Block bookkeeping: the first symbol of a block reloads rather than accumulates.
    always_comb begin
        first_s = (sym_cnt_r == {ACC_LOG2{1'b0}});
        last_s  = (sym_cnt_r == {ACC_LOG2{1'b1}});
        if (first_s) begin
            abs_acc_next_s = ACC_W'(abs1_r);
        end else begin
            abs_acc_next_s = abs_acc_r + ACC_W'(abs1_r);
        end
    end

    // Phase counter and stage-1 capture of the strobed sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= 2'd0;
            v1_r   <= 1'b0;
            s1_r   <= 18'sd0;
            abs1_r <= 18'd0;
        end else begin
            cnt_r <= (cnt_r == CNT_LAST) ? 2'd0 : cnt_r + 2'd1;
            v1_r  <= strobe_s;
            if (strobe_s) begin
                s1_r   <= x_in;
                abs1_r <= abs_sat(x_in);
            end
        end
    end

    // Stage-2 decision outputs plus the |x| statistics and threshold update.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_valid  <= 1'b0;
            sym_out    <= 2'b00;
            sym_err    <= 18'sd0;
            stat_valid <= 1'b0;
            sym_cnt_r  <= {ACC_LOG2{1'b0}};
            abs_acc_r  <= {ACC_W{1'b0}};
            ref_level  <= REF_INIT;
        end else begin
            sym_valid  <= v1_r;
            stat_valid <= v1_r && last_s;
            if (v1_r) begin
                sym_out   <= dec_s;
                sym_err   <= err_s;
                abs_acc_r <= abs_acc_next_s;
                sym_cnt_r <= sym_cnt_r + {{(ACC_LOG2-1){1'b0}}, 1'b1};
                if (last_s) begin
                    ref_level <= $signed(18'(abs_acc_next_s >> ACC_LOG2));
                end
            end
        end
    end

`ifdef RX_SLICER_ERR_POW_EN
    logic signed [35:0] sq_full_s;
    logic signed [35:0] sq_shift_s;
    logic [17:0]        sq_term_s;
    logic [ACC_W-1:0]   sq_acc_r;
    logic [ACC_W-1:0]   sq_acc_next_s;

    assign sq_full_s  = err_s * err_s;
    assign sq_shift_s = sq_full_s >>> 17;

    // Clamp the normalised square to 1s17 and accumulate it over the block.
    always_comb begin
        if (sq_shift_s > 36'sd131071) begin
            sq_term_s = 18'h1FFFF;
        end else begin
            sq_term_s = sq_shift_s[17:0];
        end
        if (first_s) begin
            sq_acc_next_s = ACC_W'(sq_term_s);
        end else begin
            sq_acc_next_s = sq_acc_r + ACC_W'(sq_term_s);
        end
    end

    // Squared-error accumulator and block mean.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_acc_r <= {ACC_W{1'b0}};
            err_pow  <= 18'd0;
        end else if (v1_r) begin
            sq_acc_r <= sq_acc_next_s;
            if (last_s) begin
                err_pow <= 18'(sq_acc_next_s >> ACC_LOG2);
            end
        end
    end
`else
    // Error power is not built in this configuration.
    always_ff @(posedge clk) begin
        err_pow <= 18'd0;
    end
`endif

    rx_symbol_slicer_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .stat_valid (stat_valid),
        .ref_level  (ref_level)
    );
endmodule

// File: tb/tb_rx_symbol_slicer.sv
// Scoreboard bench for rx_symbol_slicer with ACC_LOG2=2 (4-symbol statistics blocks).
module tb_rx_symbol_slicer;
    localparam int ACC_LOG2 = 2;
`ifdef RX_SLICER_ERR_POW_EN
    localparam bit POW_EN = 1'b1;
`else
    localparam bit POW_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         phase = 2'd0;
    logic signed [17:0] x_in = 18'sd0;
    logic               sym_valid;
    logic [1:0]         sym_out;
    logic signed [17:0] sym_err;
    logic signed [17:0] ref_level;
    logic [17:0]        err_pow;
    logic               stat_valid;

    typedef struct {
        logic [1:0]         sym;
        logic signed [17:0] err;
        int                 cyc;
    } sym_exp_t;

    typedef struct {
        logic signed [17:0] ref_l;
        logic [17:0]        pow;
        int                 cyc;
    } stat_exp_t;

    sym_exp_t  sym_q[$];
    stat_exp_t stat_q[$];
    int        n_vec = 0;
    int        n_fail = 0;
    int        cyc_r = 0;

    rx_symbol_slicer #(.ACC_LOG2(ACC_LOG2)) dut (
        .clk        (clk),
        .reset      (reset),
        .phase      (phase),
        .x_in       (x_in),
        .sym_valid  (sym_valid),
        .sym_out    (sym_out),
        .sym_err    (sym_err),
        .ref_level  (ref_level),
        .err_pow    (err_pow),
        .stat_valid (stat_valid)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first cycle in which reset is low.
    always @(posedge clk) cyc_r <= reset ? 0 : cyc_r + 1;

    function automatic logic [17:0] exp_pow(input logic [17:0] v);
        return POW_EN ? v : 18'd0;
    endfunction

    task automatic push_sym(input logic [1:0] s, input logic signed [17:0] e, input int c);
        sym_exp_t t;
        t.sym = s;
        t.err = e;
        t.cyc = c;
        sym_q.push_back(t);
    endtask

    task automatic push_stat(input logic signed [17:0] r, input logic [17:0] p, input int c);
        stat_exp_t t;
        t.ref_l = r;
        t.pow   = p;
        t.cyc   = c;
        stat_q.push_back(t);
    endtask

    // Hold reset for 3 clocks, checking the reset state after each edge.
    task automatic do_reset(input logic signed [17:0] xr);
        reset = 1'b1;
        x_in  = xr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== 1'b0 || sym_out !== 2'b00 || sym_err !== 18'sd0 ||
                ref_level !== 18'sd65536 || err_pow !== 18'd0 || stat_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: got v=%b sym=%b err=%0d ref=%0d pow=%0d sv=%b, expected v=0 sym=00 err=0 ref=65536 pow=0 sv=0",
                         sym_valid, sym_out, sym_err, ref_level, err_pow, stat_valid);
            end
        end
        reset = 1'b0;
    endtask

    // Drive len cycles: xa before cycle sw, xb after; gate>=0 zeroes x except when cycle%4==gate.
    task automatic drive(input logic [1:0] ph, input int len, input logic signed [17:0] xa,
                         input logic signed [17:0] xb, input int sw, input int gate);
        phase = ph;
        for (int k = 0; k < len; k++) begin
            x_in = (k < sw) ? xa : xb;
            if (gate >= 0 && (k % 4) != gate) x_in = 18'sd0;
            @(negedge clk);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a symbol or a statistics update.
    initial begin
        sym_exp_t  se;
        stat_exp_t te;
        forever begin
            @(negedge clk);
            if (sym_valid) begin
                n_vec++;
                if (sym_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sym_unexpected: sym_valid at cycle %0d sym_out=%b sym_err=%0d, expected no pulse",
                             cyc_r, sym_out, sym_err);
                end else begin
                    se = sym_q.pop_front();
                    if (sym_out !== se.sym || sym_err !== se.err || cyc_r != se.cyc) begin
                        n_fail++;
                        $display("FAIL sym: got cycle %0d sym_out=%b sym_err=%0d, expected cycle %0d sym_out=%b sym_err=%0d",
                                 cyc_r, sym_out, sym_err, se.cyc, se.sym, se.err);
                    end
                end
            end
            if (stat_valid) begin
                n_vec++;
                if (stat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stat_unexpected: stat_valid at cycle %0d ref=%0d pow=%0d, expected no pulse",
                             cyc_r, ref_level, err_pow);
                end else begin
                    te = stat_q.pop_front();
                    if (ref_level !== te.ref_l || err_pow !== te.pow || cyc_r != te.cyc) begin
                        n_fail++;
                        $display("FAIL stat: got cycle %0d ref=%0d pow=%0d, expected cycle %0d ref=%0d pow=%0d",
                                 cyc_r, ref_level, err_pow, te.cyc, te.ref_l, te.pow);
                    end
                end
            end
        end
    end

    initial begin
        do_reset(18'sd12345);

        // Constant +1.5a-ish input above threshold, phase 0.
        for (int i = 0; i < 4; i++) push_sym(2'b11, 18'sd0, 2 + 4 * i);
        push_stat(18'sd98304, 18'd0, 14);
        drive(2'd0, 16, 18'sd98304, 18'sd98304, 16, -1);
        do_reset(18'sd0);

        // Full-scale negative: saturated |x| and outer-level error.
        for (int i = 0; i < 4; i++) push_sym(2'b00, -18'sd32768, 3 + 4 * i);
        push_stat(18'sd131071, exp_pow(18'd8192), 15);
        drive(2'd1, 16, -18'sd131072, -18'sd131072, 16, -1);
        do_reset(18'sd0);

        // Phase select hits the non-zero sample.
        for (int i = 0; i < 4; i++) push_sym(2'b10, 18'sd7232, 4 + 4 * i);
        push_stat(18'sd40000, exp_pow(18'd399), 16);
        drive(2'd2, 16, 18'sd40000, 18'sd40000, 16, 2);
        do_reset(18'sd0);

        // Phase select misses it and sees zeros.
        for (int i = 0; i < 4; i++) push_sym(2'b10, -18'sd32768, 3 + 4 * i);
        push_stat(18'sd0, exp_pow(18'd8192), 15);
        drive(2'd1, 16, 18'sd40000, 18'sd40000, 16, 2);
        do_reset(18'sd0);

        // Partial block discarded by a mid-block reset.
        push_sym(2'b00, -18'sd32768, 2);
        push_sym(2'b00, -18'sd32768, 6);
        drive(2'd0, 8, -18'sd131072, -18'sd131072, 8, -1);
        do_reset(18'sd0);
        for (int i = 0; i < 4; i++) push_sym(2'b11, 18'sd0, 2 + 4 * i);
        push_stat(18'sd98304, 18'd0, 14);
        drive(2'd0, 16, 18'sd98304, 18'sd98304, 16, -1);
        do_reset(18'sd0);

        // Two blocks: second block is sliced with the adapted threshold.
        for (int i = 0; i < 4; i++) push_sym(2'b11, 18'sd0, 2 + 4 * i);
        push_stat(18'sd98304, 18'd0, 14);
        for (int i = 0; i < 4; i++) push_sym(2'b01, 18'sd9152, 18 + 4 * i);
        push_stat(18'sd40000, exp_pow(18'd639), 30);
        drive(2'd0, 32, 18'sd98304, -18'sd40000, 16, -1);
        do_reset(18'sd0);

        n_vec++;
        if (sym_q.size() != 0) begin
            n_fail++;
            $display("FAIL sym_missing: %0d expected symbols never appeared, required 0", sym_q.size());
        end
        n_vec++;
        if (stat_q.size() != 0) begin
            n_fail++;
            $display("FAIL stat_missing: %0d expected stat pulses never appeared, required 0", stat_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
